// File: rtl/mealy_stream_sequencer.sv
// Word-to-bit sequencer for a 2-bit serial Mealy FSM: shifts a word out LSB-first,
// collects the FSM's z bits into a result word, valid/ready on both sides.
//
// Ports:
//   clk, rst_n            clock, synchronous active-low reset
//   in_valid/in_ready     input word handshake, in_data = word (bit 0 sent first)
//   fsm_x/fsm_en          serial bit and advance enable to the FSM
//   fsm_clear             returns the FSM to S0 on the accepting edge
//   fsm_z                 FSM Mealy output for current state and fsm_x
//   out_valid/out_ready   result handshake, out_data[i] = z produced by in_data[i]
//   ones_cnt              number of 1s in the result (SEQ_ONES_COUNT_EN only)
//
// Build option: define SEQ_ONES_COUNT_EN to add the ones_cnt output.

module mealy_stream_sequencer #(
   parameter int WIDTH          = 8,
   parameter int CLEAR_ON_START = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             fsm_x,
   output logic             fsm_en,
   output logic             fsm_clear,
   input  logic             fsm_z,
   output logic             out_valid,
   input  logic             out_ready,
`ifdef SEQ_ONES_COUNT_EN
   output logic [WIDTH-1:0] out_data,
   output logic [$clog2(WIDTH+1)-1:0] ones_cnt
`else
   output logic [WIDTH-1:0] out_data
`endif
);

   localparam int CW = $clog2(WIDTH);

   typedef enum logic [1:0] {
      S_IDLE,
      S_SHIFT,
      S_DONE
   } state_t;

   state_t           r_state;
   logic             r_in_ready;
   logic             r_fsm_en;
   logic             r_out_valid;
   logic [WIDTH-1:0] r_shreg;
   logic [WIDTH-1:0] r_res;
   logic [CW-1:0]    r_cnt;

   logic             w_accept;
   logic             w_last;
   logic [WIDTH-1:0] w_res_nxt;

`ifdef SEQ_ONES_COUNT_EN
   localparam int OW = $clog2(WIDTH+1);
   logic [OW-1:0] r_ones;
   assign ones_cnt = r_ones;
`endif

   // r_in_ready is only ever set while in S_IDLE
   assign w_accept  = in_valid & r_in_ready;
   assign w_last    = (r_cnt == CW'(WIDTH-1));
   assign w_res_nxt = {fsm_z, r_res[WIDTH-1:1]};

   assign in_ready  = r_in_ready;
   assign fsm_en    = r_fsm_en;
   // shreg drains to zero, but gate anyway so fsm_x is 0 outside SHIFT
   assign fsm_x     = r_fsm_en & r_shreg[0];
   // clear lands on the accepting edge so the first bit sees S0
   assign fsm_clear = (CLEAR_ON_START != 0) & w_accept;
   assign out_valid = r_out_valid;
   assign out_data  = r_res;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_in_ready  <= 1'b0;
         r_fsm_en    <= 1'b0;
         r_out_valid <= 1'b0;
         r_shreg     <= '0;
         r_res       <= '0;
         r_cnt       <= '0;
`ifdef SEQ_ONES_COUNT_EN
         r_ones      <= '0;
`endif
      end else begin
         unique case (r_state)
            S_IDLE: begin
               r_in_ready <= 1'b1;
               if (w_accept) begin
                  r_in_ready <= 1'b0;
                  r_shreg    <= in_data;
                  r_res      <= '0;
                  r_cnt      <= '0;
                  r_fsm_en   <= 1'b1;
                  r_state    <= S_SHIFT;
`ifdef SEQ_ONES_COUNT_EN
                  r_ones     <= '0;
`endif
               end
            end
            S_SHIFT: begin
               r_res   <= w_res_nxt;
               r_shreg <= r_shreg >> 1;
`ifdef SEQ_ONES_COUNT_EN
               r_ones  <= r_ones + OW'(fsm_z);
`endif
               if (w_last) begin
                  r_fsm_en    <= 1'b0;
                  r_out_valid <= 1'b1;
                  r_state     <= S_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mealy_stream_sequencer.sv
// Bench for mealy_stream_sequencer: two instances (clear on start / carry over),
// each driving a behavioural 4-state Mealy FSM.

module tb_mealy_stream_sequencer;

   localparam int W = 8;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_errors = 0;

   logic         a_in_valid, a_in_ready, a_fsm_x, a_fsm_en, a_fsm_clear;
   logic         a_fsm_z, a_out_valid, a_out_ready;
   logic [W-1:0] a_in_data, a_out_data;
   logic         b_in_valid, b_in_ready, b_fsm_x, b_fsm_en, b_fsm_clear;
   logic         b_fsm_z, b_out_valid, b_out_ready;
   logic [W-1:0] b_in_data, b_out_data;
`ifdef SEQ_ONES_COUNT_EN
   logic [3:0]   a_ones, b_ones;
`endif

   mealy_stream_sequencer #(.WIDTH(W), .CLEAR_ON_START(1)) u_a (
      .clk(clk), .rst_n(rst_n),
      .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
      .fsm_x(a_fsm_x), .fsm_en(a_fsm_en), .fsm_clear(a_fsm_clear),
      .fsm_z(a_fsm_z),
      .out_valid(a_out_valid), .out_ready(a_out_ready),
`ifdef SEQ_ONES_COUNT_EN
      .ones_cnt(a_ones),
`endif
      .out_data(a_out_data)
   );

   mealy_stream_sequencer #(.WIDTH(W), .CLEAR_ON_START(0)) u_b (
      .clk(clk), .rst_n(rst_n),
      .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
      .fsm_x(b_fsm_x), .fsm_en(b_fsm_en), .fsm_clear(b_fsm_clear),
      .fsm_z(b_fsm_z),
      .out_valid(b_out_valid), .out_ready(b_out_ready),
`ifdef SEQ_ONES_COUNT_EN
      .ones_cnt(b_ones),
`endif
      .out_data(b_out_data)
   );

   // returns {z, next_state}
   function automatic logic [2:0] fsm_step(input logic [1:0] s, input logic x);
      case (s)
         2'd0:    fsm_step = x ? {1'b0, 2'd2} : {1'b1, 2'd1};
         2'd1:    fsm_step = x ? {1'b1, 2'd3} : {1'b0, 2'd2};
         2'd2:    fsm_step = x ? {1'b1, 2'd3} : {1'b0, 2'd1};
         default: fsm_step = x ? {1'b0, 2'd0} : {1'b1, 2'd2};
      endcase
   endfunction

   logic [1:0] a_st, b_st;
   logic [2:0] a_nx, b_nx;
   assign a_nx    = fsm_step(a_st, a_fsm_x);
   assign b_nx    = fsm_step(b_st, b_fsm_x);
   assign a_fsm_z = a_nx[2];
   assign b_fsm_z = b_nx[2];

   always @(posedge clk) begin
      if (!rst_n)           a_st <= 2'd0;
      else if (a_fsm_clear) a_st <= 2'd0;
      else if (a_fsm_en)    a_st <= a_nx[1:0];
      if (!rst_n)           b_st <= 2'd0;
      else if (b_fsm_clear) b_st <= 2'd0;
      else if (b_fsm_en)    b_st <= b_nx[1:0];
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic run_a(input logic [W-1:0] d, input logic [W-1:0] exp,
                        input int exp_ones, input int hold);
      int n;
      n = 0;
      a_out_ready = (hold == 0);
      while (!a_in_ready && n < 30) begin
         step();
         n++;
      end
      check("a_ready_pre", 32'(a_in_ready), 1);
      a_in_data  = d;
      a_in_valid = 1'b1;
      #1;
      check("a_clear", 32'(a_fsm_clear), 1);
      step();
      a_in_valid = 1'b0;
      a_in_data  = ~d;
      for (int i = 0; i < W; i++) begin
         check("a_fsm_x", 32'(a_fsm_x), 32'(d[i]));
         check("a_fsm_en", 32'(a_fsm_en), 1);
         check("a_busy_rdy", 32'(a_in_ready), 0);
         check("a_early_ov", 32'(a_out_valid), 0);
         step();
      end
      check("a_out_valid", 32'(a_out_valid), 1);
      check("a_out_data", 32'(a_out_data), 32'(exp));
      check("a_done_en", 32'(a_fsm_en), 0);
      check("a_done_x", 32'(a_fsm_x), 0);
`ifdef SEQ_ONES_COUNT_EN
      check("a_ones", 32'(a_ones), 32'(exp_ones));
`endif
      for (int k = 0; k < hold; k++) begin
         check("bp_valid", 32'(a_out_valid), 1);
         check("bp_data", 32'(a_out_data), 32'(exp));
         check("bp_ready", 32'(a_in_ready), 0);
`ifdef SEQ_ONES_COUNT_EN
         check("bp_ones", 32'(a_ones), 32'(exp_ones));
`endif
         a_in_valid = (k % 2 == 0);
         a_in_data  = 8'hFF;
         step();
      end
      a_in_valid  = 1'b0;
      a_out_ready = 1'b1;
      step();
      check("a_back_idle", 32'(a_in_ready), 1);
      check("a_ov_drop", 32'(a_out_valid), 0);
   endtask

   task automatic run_b(input logic [W-1:0] d, input logic [W-1:0] exp,
                        input int exp_ones);
      int n;
      n = 0;
      while (!b_in_ready && n < 30) begin
         step();
         n++;
      end
      check("b_ready_pre", 32'(b_in_ready), 1);
      b_in_data  = d;
      b_in_valid = 1'b1;
      #1;
      check("b_no_clear", 32'(b_fsm_clear), 0);
      step();
      b_in_valid = 1'b0;
      n = 0;
      while (!b_out_valid && n < 30) begin
         step();
         n++;
      end
      check("b_out_valid", 32'(b_out_valid), 1);
      check("b_out_data", 32'(b_out_data), 32'(exp));
`ifdef SEQ_ONES_COUNT_EN
      check("b_ones", 32'(b_ones), 32'(exp_ones));
`endif
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      a_in_valid = 1'b0; a_in_data = '0; a_out_ready = 1'b1;
      b_in_valid = 1'b0; b_in_data = '0; b_out_ready = 1'b1;
      rst_n = 1'b0;

      repeat (2) @(posedge clk);
      #1;
      check("rst_ov", 32'(a_out_valid), 0);
      check("rst_rdy", 32'(a_in_ready), 0);
      check("rst_en", 32'(a_fsm_en), 0);
      check("rst_data", 32'(a_out_data), 0);
      check("rst_x", 32'(a_fsm_x), 0);
`ifdef SEQ_ONES_COUNT_EN
      check("rst_ones", 32'(a_ones), 0);
`endif
      rst_n = 1'b1;
      check("rel_rdy0", 32'(a_in_ready), 0);
      step();
      check("rel_rdy1", 32'(a_in_ready), 1);

      run_a(8'h5C, 8'hC5, 4, 0);
      run_a(8'h00, 8'h01, 1, 0);
      run_a(8'h00, 8'h01, 1, 0);
      run_a(8'h5C, 8'hC5, 4, 5);

      // abort a word three bits in
      a_in_data  = 8'h5C;
      a_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("ab_fsm_x", 32'(a_fsm_x), 32'((8'h5C >> i) & 1));
         step();
      end
      rst_n = 1'b0;
      step();
      check("ab_rdy", 32'(a_in_ready), 0);
      check("ab_en", 32'(a_fsm_en), 0);
      check("ab_x", 32'(a_fsm_x), 0);
      check("ab_ov", 32'(a_out_valid), 0);
      check("ab_data", 32'(a_out_data), 0);
      rst_n = 1'b1;
      step();
      check("ab_rdy1", 32'(a_in_ready), 1);
      run_a(8'h5C, 8'hC5, 4, 0);

      run_b(8'h5C, 8'hC5, 4);
      run_b(8'h00, 8'h00, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
